// File: rtl/gshare_branch_pred_pkg.sv
// Shared definitions for the fetch-stage branch predictors: opcode constants,
// word width, B-type immediate decode, predictor mode ids and counter update.
package opcodes;
    localparam logic [6:0] BRANCH_OP = 7'b1100011;
endpackage

package predictors;
    localparam int unsigned word_width = 32;

    localparam int unsigned PRED_NT      = 0;
    localparam int unsigned PRED_T       = 1;
    localparam int unsigned PRED_BTFN    = 2;
    localparam int unsigned PRED_BIMODAL = 3;
    localparam int unsigned PRED_GSHARE  = 4;

    // Sign-extended B-type immediate (conditional branch offset).
    function automatic logic [word_width-1:0] get_imm(
        input logic [word_width-1:0] inst
    );
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // Saturating up/down counter step, saturating at 0 and 2^width-1.
    function automatic logic [31:0] sat_update(
        input logic [31:0] ctr,
        input logic        taken,
        input int unsigned width
    );
        logic [31:0] max;
        max = (32'd1 << width) - 32'd1;
        if (taken) return (ctr >= max) ? max : ctr + 32'd1;
        else       return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction
endpackage

// File: rtl/gshare_branch_pred_pend_fifo.sv
// In-order queue of PHT indices for branches awaiting resolution.
// Ports: push/din enqueue, pop dequeue, flush clear, head/full/empty status.
module pred_pend_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[head_q];
    assign do_pop  = pop && !empty;
    // A full queue still accepts when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_pop)  head_d = head_q + PW'(1);
            if (do_push) tail_d = tail_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[tail_q] <= din;
    end
endmodule

// File: rtl/gshare_branch_pred.sv
// Fetch-stage branch direction/target predictor with selectable strategy.
// Ports: fetch side (pred_valid, inst_in, inst_addr -> branch_predicted,
// branch_addr, pend_full), execute side (resolve_valid, branch_taken, flush).
module gshare_branch_pred
    import opcodes::*;
    import predictors::*;
#(
    parameter int unsigned mode          = 4,
    parameter int unsigned idx_width     = 6,
    parameter int unsigned ghr_width     = 4,
    parameter int unsigned counter_width = 2,
    parameter int unsigned pend_depth    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pred_valid,
    input  logic [word_width-1:0] inst_in,
    input  logic [word_width-1:0] inst_addr,
    output logic                  branch_predicted,
    output logic [word_width-1:0] branch_addr,
    output logic                  pend_full,
    input  logic                  resolve_valid,
    input  logic                  branch_taken,
    input  logic                  flush
);
    localparam int unsigned ENTRIES = 2 ** idx_width;
    localparam logic [counter_width-1:0] PHT_RST =
        counter_width'((1 << (counter_width - 1)) - 1);

    logic [counter_width-1:0] pht_q [ENTRIES];
    logic [counter_width-1:0] ctr_d;
    logic [ghr_width-1:0]     ghr_q, ghr_d;
    logic [idx_width-1:0]     base_idx, idx, head_idx;
    logic [word_width-1:0]    imm;
    logic                     is_br, accept, dir, pop;
    logic                     fifo_full, fifo_empty;

    assign imm      = get_imm(inst_in);
    assign is_br    = pred_valid && (inst_in[6:0] == BRANCH_OP);
    assign base_idx = inst_addr[idx_width+1:2];
    assign idx      = (mode == PRED_GSHARE)
                    ? base_idx ^ idx_width'(ghr_q)
                    : base_idx;

    always_comb begin
        dir = 1'b0;
        case (mode)
            PRED_NT:   dir = 1'b0;
            PRED_T:    dir = 1'b1;
            PRED_BTFN: dir = imm[word_width-1];
            default:   dir = pht_q[idx][counter_width-1];
        endcase
    end

    assign accept           = is_br && (!fifo_full || resolve_valid) && !flush;
    assign branch_predicted = accept && dir;
    assign branch_addr      = inst_addr + imm;
    assign pend_full        = fifo_full;

    // Training uses the index captured at prediction time, not the current one.
    assign pop   = resolve_valid && !fifo_empty;
    assign ctr_d = counter_width'(sat_update(32'(pht_q[head_idx]),
                                             branch_taken, counter_width));
    assign ghr_d = pop ? ((ghr_q << 1) | ghr_width'(branch_taken)) : ghr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= PHT_RST;
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
            if (pop) pht_q[head_idx] <= ctr_d;
        end
    end

    pred_pend_fifo #(
        .WIDTH(idx_width),
        .DEPTH(pend_depth)
    ) u_pend (
        .clk  (clk),
        .reset(reset),
        .push (accept),
        .pop  (resolve_valid),
        .flush(flush),
        .din  (idx),
        .head (head_idx),
        .full (fifo_full),
        .empty(fifo_empty)
    );
endmodule

// File: tb/tb_gshare_branch_pred.sv
// Scoreboard bench: all five predictor modes driven with identical stimulus
// and compared against a behavioural model of the prediction rules.
module tb_gshare_branch_pred;
    typedef logic [4:0][5:0] idxv_t;
    typedef struct packed {
        logic [4:0]  pred;
        logic [31:0] addr;
        logic        full;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, pred_valid, resolve_valid, branch_taken, flush;
    logic [31:0] inst_in, inst_addr;
    logic [4:0]  bp, pf;
    logic [31:0] ba [5];

    int    checks = 0;
    int    failures = 0;
    int    pht [5][64];
    int    ghr [5];
    idxv_t pq [$];
    exp_t  sb [$];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 5; m++) begin : g_dut
        gshare_branch_pred #(.mode(m)) dut (
            .clk             (clk),
            .reset           (reset),
            .pred_valid      (pred_valid),
            .inst_in         (inst_in),
            .inst_addr       (inst_addr),
            .branch_predicted(bp[m]),
            .branch_addr     (ba[m]),
            .pend_full       (pf[m]),
            .resolve_valid   (resolve_valid),
            .branch_taken    (branch_taken),
            .flush           (flush)
        );
    end

    task automatic chk(input string name, input int m,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s mode=%0d got=%h want=%h t=%0t",
                     name, m, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int m = 0; m < 5; m++) begin
                chk("pred", m, 32'(bp[m]), 32'(e.pred[m]));
                chk("addr", m, ba[m], e.addr);
                chk("full", m, 32'(pf[m]), 32'(e.full));
            end
        end
    end

    function automatic void model_reset();
        for (int m = 0; m < 5; m++) begin
            for (int i = 0; i < 64; i++) pht[m][i] = 1;
            ghr[m] = 0;
        end
        pq.delete();
    endfunction

    function automatic logic [31:0] enc(input bit isbr, input int imm,
                                        input logic [31:0] rnd);
        logic [12:0] b;
        logic [6:0]  op;
        b  = 13'(imm);
        op = isbr ? 7'b1100011 : 7'b0010011;
        return {b[12], b[10:5], rnd[24:12], b[4:1], b[11], op};
    endfunction

    task automatic step(input bit pv, input bit isbr, input logic [31:0] addr,
                        input int imm, input bit rv, input bit bt,
                        input bit fl);
        exp_t       e;
        idxv_t      iv, hv;
        bit         acc, full, d;
        logic [5:0] base;
        int         h;
        inst_in       = enc(isbr, imm, $urandom);
        pred_valid    = pv;
        inst_addr     = addr;
        resolve_valid = rv;
        branch_taken  = bt;
        flush         = fl;
        full = (pq.size() == 4);
        acc  = pv && isbr && (!full || rv) && !fl;
        base = addr[7:2];
        for (int m = 0; m < 5; m++) begin
            iv[m] = (m == 4) ? base ^ 6'(ghr[m]) : base;
            case (m)
                0:       d = 1'b0;
                1:       d = 1'b1;
                2:       d = (imm < 0);
                default: d = (pht[m][iv[m]] >= 2);
            endcase
            e.pred[m] = acc && d;
        end
        e.addr = addr + 32'(imm);
        e.full = full;
        sb.push_back(e);
        if (rv && pq.size() > 0) begin
            hv = pq.pop_front();
            for (int m = 0; m < 5; m++) begin
                h = int'(hv[m]);
                if (bt) pht[m][h] = (pht[m][h] < 3) ? pht[m][h] + 1 : 3;
                else    pht[m][h] = (pht[m][h] > 0) ? pht[m][h] - 1 : 0;
                ghr[m] = ((ghr[m] << 1) | int'(bt)) & 15;
            end
        end
        if (fl) pq.delete();
        else if (acc) pq.push_back(iv);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rv, input bit bt, input bit fl);
        step(1'b0, 1'b0, 32'h0, 0, rv, bt, fl);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        pred_valid    = 1'b0;
        resolve_valid = 1'b0;
        branch_taken  = 1'b0;
        flush         = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        inst_in   = '0;
        inst_addr = '0;
        do_reset();

        step(1, 1, 32'h100, 16, 0, 0, 0);
        idle(0, 0, 1);

        step(1, 1, 32'h40, 8, 0, 0, 0);
        repeat (6) step(1, 1, 32'h40, 8, 1, 1, 0);
        idle(1, 1, 0);
        step(1, 1, 32'h40, 8, 0, 0, 0);
        idle(0, 0, 1);

        do_reset();
        step(1, 1, 32'h200, 8, 0, 0, 0);
        step(1, 1, 32'h204, 8, 0, 0, 0);
        idle(1, 1, 0);
        idle(1, 1, 0);
        step(1, 1, 32'h0, 8, 0, 0, 0);
        idle(1, 1, 0);
        step(1, 1, 32'h0, 8, 0, 0, 0);
        step(1, 1, 32'hC, 8, 0, 0, 0);
        idle(0, 0, 1);

        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 32'(i * 4), 8, 0, 0, 0);
        step(1, 1, 32'h10, 8, 0, 0, 0);
        step(1, 1, 32'h14, 8, 1, 1, 0);
        idle(0, 0, 0);
        idle(1, 1, 0);
        idle(1, 1, 1);
        idle(1, 0, 0);
        step(1, 1, 32'h8, 8, 0, 0, 0);
        idle(0, 0, 1);

        step(1, 1, 32'h300, -8, 0, 0, 0);
        step(1, 1, 32'h300, 8, 0, 0, 0);
        step(1, 0, 32'h300, -8, 1, 0, 0);
        idle(1, 0, 0);
        idle(1, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 7,
                     ($urandom & 32'hFFFF_F000) |
                         32'({$urandom_range(0, 255), 2'b00}),
                     (int'($urandom_range(0, 4095)) - 2048) * 2,
                     $urandom_range(0, 9) < 4,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 19) == 0);
            end
        end

        idle(0, 0, 0);
        @(negedge clk);
        #1;
        chk("sb_drained", 0, 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
